// File: rtl/readout_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : readout_fifo_ctrl_if
//  Description : Upstream valid/ready handshake, downstream serializer
//                handshake and dual-port DFF RAM bus of the readout FIFO
//                controller, grouped into one interface.
//                slave  : the FIFO controller side
//                master : the surrounding collector / serializer / RAM side
//  Revision    : 1.0  initial release
// ============================================================================
interface readout_fifo_ctrl_if #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 5
);
    // upstream collector -> FIFO
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    // FIFO -> downstream serializer
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    // FIFO <-> RAM
    logic              ram_cs_n;
    logic              ram_wr_n;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_data_in;
    logic [DATA_W-1:0] ram_rd_data;

    modport slave (
        input  in_valid, in_data, out_ready, ram_rd_data,
        output in_ready, out_valid, out_data,
               ram_cs_n, ram_wr_n, ram_wr_addr, ram_rd_addr, ram_data_in
    );

    modport master (
        output in_valid, in_data, out_ready, ram_rd_data,
        input  in_ready, out_valid, out_data,
               ram_cs_n, ram_wr_n, ram_wr_addr, ram_rd_addr, ram_data_in
    );
endinterface
`default_nettype wire

// File: rtl/readout_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : readout_fifo_ctrl
//  Description : FIFO controller in front of a 2**ADDR_W x DATA_W dual-port
//                DFF RAM with asynchronous read. Wrapping write/read
//                pointers, registered occupancy count, full/empty and
//                almost-full flags, sticky overflow flag, synchronous flush.
//                The oldest word is passed straight through from the RAM
//                read port (no output register, no fall-through).
//  Revision    : 1.0  initial release
// ============================================================================
module readout_fifo_ctrl #(
    parameter int DATA_W   = 24,
    parameter int DEPTH    = 32,   // must equal 2**ADDR_W
    parameter int ADDR_W   = 5,
    parameter int AFULL_TH = 28
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              flush_i,
    readout_fifo_ctrl_if.slave     fifo_if,
    output logic [ADDR_W:0]        count_o,
    output logic                   almost_full_o,
    output logic                   err_ovf_o
);

    localparam logic [ADDR_W:0]   c_DEPTH   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_AFULL   = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0]   c_CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_PTR_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic              err_ovf_q, err_ovf_d;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_wr_data;
    logic [DATA_W-1:0] w_rd_data;

    // All flags decode from the registered count only.
    assign w_full  = (count_q == c_DEPTH);
    assign w_empty = (count_q == '0);

    // in_ready ignores out_ready: a pop in the same cycle never frees a slot
    // early, and an empty FIFO never pops in the cycle it is written.
    assign w_push = fifo_if.in_valid  & ~w_full;
    assign w_pop  = fifo_if.out_ready & ~w_empty;

    assign w_wr_data = fifo_if.in_data;
    assign w_rd_data = fifo_if.ram_rd_data;

    assign fifo_if.in_ready    = ~w_full;
    assign fifo_if.out_valid   = ~w_empty;
    assign fifo_if.out_data    = w_rd_data;
    assign fifo_if.ram_data_in = w_wr_data;
    assign fifo_if.ram_wr_addr = wr_ptr_q;
    assign fifo_if.ram_rd_addr = rd_ptr_q;
    // RAM is deselected and write-protected for as long as reset is held.
    assign fifo_if.ram_cs_n    = ~rst_n;
    assign fifo_if.ram_wr_n    = ~(w_push & ~flush_i & rst_n);

    assign count_o       = count_q;
    assign almost_full_o = (count_q >= c_AFULL);
    assign err_ovf_o     = err_ovf_q;

    // Next-state: flush wins over everything; otherwise advance pointers on
    // push/pop and track occupancy and overflow.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_ovf_d = err_ovf_q;
        if (flush_i) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            err_ovf_d = 1'b0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + c_PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                count_d = count_q + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                count_d = count_q - c_CNT_ONE;
            end
            // A word offered while full is dropped and flagged.
            if (fifo_if.in_valid && w_full) begin
                err_ovf_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_ovf_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_ovf_q <= err_ovf_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_readout_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_readout_fifo_ctrl
//  Description : Self-checking bench for readout_fifo_ctrl with a behavioural
//                24x32 DFF RAM, a reference occupancy model and a data
//                scoreboard queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_readout_fifo_ctrl;

    localparam int DATA_W = 24;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int AFULL  = 28;

    logic clk;
    logic rst_n;
    logic flush;
    logic [ADDR_W:0] count;
    logic almost_full;
    logic err_ovf;

    readout_fifo_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    readout_fifo_ctrl #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .AFULL_TH(AFULL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush),
        .fifo_if      (bus.slave),
        .count_o      (count),
        .almost_full_o(almost_full),
        .err_ovf_o    (err_ovf)
    );

    // Behavioural RAM: synchronous write, asynchronous read.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (!bus.ram_cs_n && !bus.ram_wr_n) mem[bus.ram_wr_addr] <= bus.ram_data_in;
    end
    assign bus.ram_rd_data = mem[bus.ram_rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model
    int                m_cnt;
    bit                m_ovf;
    logic [DATA_W-1:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: check outputs at negedge against the model, then let the
    // edge happen and update the model / scoreboard.
    task automatic cycle();
        bit push, pop;
        int old_cnt;
        @(negedge clk);
        push = bus.in_valid && (m_cnt != DEPTH) && !flush;
        pop  = bus.out_ready && (m_cnt != 0) && !flush;
        chk("in_ready",    32'(bus.in_ready),  32'(m_cnt != DEPTH));
        chk("out_valid",   32'(bus.out_valid), 32'(m_cnt != 0));
        chk("count",       32'(count),         32'(m_cnt));
        chk("almost_full", 32'(almost_full),   32'(m_cnt >= AFULL));
        chk("err_ovf",     32'(err_ovf),       32'(m_ovf));
        chk("ram_cs_n",    32'(bus.ram_cs_n),  32'(0));
        chk("ram_wr_n",    32'(bus.ram_wr_n),  32'(!push));
        if (m_cnt != 0) chk("out_data", 32'(bus.out_data), 32'(sb[0]));
        @(posedge clk);
        old_cnt = m_cnt;
        if (flush) begin
            sb.delete();
            m_cnt = 0;
            m_ovf = 1'b0;
        end else begin
            if (pop)  void'(sb.pop_front());
            if (push) sb.push_back(bus.in_data);
            m_cnt = m_cnt + int'(push) - int'(pop);
            if (bus.in_valid && old_cnt == DEPTH) m_ovf = 1'b1;
        end
        #1;
    endtask

    task automatic drive(input bit v, input bit r, input bit f, input logic [DATA_W-1:0] d);
        bus.in_valid  = v;
        bus.out_ready = r;
        flush         = f;
        bus.in_data   = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count",     32'(count),         32'(0));
        chk("rst_in_ready",  32'(bus.in_ready),  32'(1));
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_ram_cs_n",  32'(bus.ram_cs_n),  32'(1));
        chk("rst_ram_wr_n",  32'(bus.ram_wr_n),  32'(1));
        rst_n = 1'b1;
        m_cnt = 0;
        m_ovf = 1'b0;
        sb.delete();
    endtask

    typedef struct {
        bit                v;
        bit                r;
        bit                f;
        logic [DATA_W-1:0] d;
        int                exp_cnt;   // count after the edge
        bit                exp_ovf;   // err_ovf after the edge
    } vec_t;

    vec_t tbl[12];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Short sequence: fill 3, push+pop, drain, push into empty with
        // out_ready high, flush with a competing push.
        tbl[0]  = '{1, 0, 0, 24'hA00001, 1, 0};
        tbl[1]  = '{1, 0, 0, 24'hA00002, 2, 0};
        tbl[2]  = '{1, 0, 0, 24'hA00003, 3, 0};
        tbl[3]  = '{0, 0, 0, 24'h000000, 3, 0};
        tbl[4]  = '{1, 1, 0, 24'hA00004, 3, 0};
        tbl[5]  = '{0, 1, 0, 24'h000000, 2, 0};
        tbl[6]  = '{0, 1, 0, 24'h000000, 1, 0};
        tbl[7]  = '{0, 1, 0, 24'h000000, 0, 0};
        tbl[8]  = '{0, 1, 0, 24'h000000, 0, 0};
        tbl[9]  = '{1, 1, 0, 24'h123456, 1, 0};
        tbl[10] = '{0, 0, 0, 24'h000000, 1, 0};
        tbl[11] = '{1, 0, 1, 24'hBADBAD, 0, 0};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].v, tbl[i].r, tbl[i].f, tbl[i].d);
            cycle();
            chk($sformatf("tbl%0d_count", i),   32'(count),   32'(tbl[i].exp_cnt));
            chk($sformatf("tbl%0d_err_ovf", i), 32'(err_ovf), 32'(tbl[i].exp_ovf));
        end
        drive(0, 0, 0, '0);
        cycle();

        // Fill to full, then overflow attempt.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 0, 0, DATA_W'(i));
            cycle();
            if (i == AFULL - 2) chk("afull_below_th", 32'(almost_full), 32'(0));
            if (i == AFULL - 1) chk("afull_at_th",    32'(almost_full), 32'(1));
        end
        drive(1, 0, 0, 24'hFFFFFF);
        cycle();
        chk("ovf_count", 32'(count),        32'(DEPTH));
        chk("ovf_flag",  32'(err_ovf),      32'(1));
        chk("full_rdy",  32'(bus.in_ready), 32'(0));

        // Drain everything in order across the read pointer wrap.
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 1, 0, '0);
            cycle();
        end
        drive(0, 0, 0, '0);
        cycle();
        chk("drained_valid", 32'(bus.out_valid), 32'(0));

        // Steady state at count 5 with simultaneous push/pop.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 24'hC00000 | DATA_W'(i));
            cycle();
        end
        for (int i = 5; i < 45; i++) begin
            drive(1, 1, 0, 24'hC00000 | DATA_W'(i));
            cycle();
            chk("steady_count", 32'(count), 32'(5));
        end
        drive(0, 1, 0, '0);
        repeat (6) cycle();

        // Count 10 with err_ovf set, then flush.
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive(1, 0, 0, 24'hD00000 | DATA_W'(i));
            cycle();
        end
        for (int i = 0; i < DEPTH - 10; i++) begin
            drive(0, 1, 0, '0);
            cycle();
        end
        chk("pre_flush_count", 32'(count),   32'(10));
        chk("pre_flush_ovf",   32'(err_ovf), 32'(1));
        drive(0, 1, 1, '0);
        cycle();
        chk("flush_count", 32'(count),         32'(0));
        chk("flush_valid", 32'(bus.out_valid), 32'(0));
        chk("flush_ovf",   32'(err_ovf),       32'(0));
        drive(0, 0, 0, '0);
        cycle();

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 30; i++) begin
            drive(1, 0, 0, 24'hE00000 | DATA_W'(i));
            cycle();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count",     32'(count),         32'(0));
        chk("arst_in_ready",  32'(bus.in_ready),  32'(1));
        chk("arst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("arst_afull",     32'(almost_full),   32'(0));
        chk("arst_ovf",       32'(err_ovf),       32'(0));
        chk("arst_ram_cs_n",  32'(bus.ram_cs_n),  32'(1));
        chk("arst_ram_wr_n",  32'(bus.ram_wr_n),  32'(1));
        do_reset();
        drive(1, 0, 0, 24'h5A5A5A);
        cycle();
        drive(0, 0, 0, '0);
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
